// File: rtl/reset_sequencer_if.sv
// Reset sequencer signal bundle: reset sources in, staged resets and status out.
// Latency: none (wiring only).
// Backpressure: none; every signal is a level.
interface reset_sequencer_if #(
  parameter int MODE_W     = 2,
  parameter int NUM_STAGES = 3
);
  logic                  pll_locked;
  logic                  osd_reset;
  logic                  button_reset;
  logic [MODE_W-1:0]     mode;
  logic [NUM_STAGES-1:0] rst_out;
  logic [MODE_W-1:0]     mode_latched;
  logic                  busy;
  logic [3:0]            reset_cause;
  logic [7:0]            reset_count;

  // Source side: drives reset requests, observes the staged resets.
  modport master (
    output pll_locked, osd_reset, button_reset, mode,
    input  rst_out, mode_latched, busy, reset_cause, reset_count
  );

  // Sequencer side.
  modport slave (
    input  pll_locked, osd_reset, button_reset, mode,
    output rst_out, mode_latched, busy, reset_cause, reset_count
  );
endinterface

// File: rtl/reset_sequencer.sv
// System reset controller: merges reset sources, holds, then releases stages in order.
// Latency: a trigger asserts all stages on the next edge; PLL loss takes 3 edges (2 sync + 1).
// Backpressure: none; any trigger immediately restarts the hold and wins over releases.
module reset_sequencer #(
  parameter int MODE_W      = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_GAP   = 4
) (
  input logic              clk_sys,
  input logic              reset_n,
  reset_sequencer_if.slave bus
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GAP_W  = (STAGE_GAP > 1)   ? $clog2(STAGE_GAP)   : 1;
  localparam int IDX_W  = (NUM_STAGES > 1)  ? $clog2(NUM_STAGES)  : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]      stage_idx_q, stage_idx_d;
  logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
  logic                  busy_q, busy_d;
  logic [MODE_W-1:0]     mode_latched_q, mode_latched_d;
  logic [3:0]            cause_q, cause_d;
  logic [7:0]            count_q, count_d;
  logic                  pll_meta_q, pll_s_q;

  logic [3:0]            src;
  logic                  trig;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pll_meta_q <= 1'b0;
      pll_s_q    <= 1'b0;
    end else begin
      pll_meta_q <= bus.pll_locked;
      pll_s_q    <= pll_meta_q;
    end
  end

  // Active sources, ordered {mode_change, button, osd, pll_unlock}.
  assign src  = {(bus.mode != mode_latched_q), bus.button_reset, bus.osd_reset, ~pll_s_q};
  assign trig = |src;

  // Next-state logic: triggers restart the hold, otherwise hold/release/run progress.
  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    stage_idx_d    = stage_idx_q;
    rst_out_d      = rst_out_q;
    mode_latched_d = mode_latched_q;
    cause_d        = cause_q;
    count_d        = count_q;

    // Track the selector while held so the release uses a settled mode.
    if (state_q == ST_HOLD) begin
      mode_latched_d = bus.mode;
    end

    if (trig) begin
      state_d     = ST_HOLD;
      hold_cnt_d  = '0;
      gap_cnt_d   = '0;
      stage_idx_d = '0;
      rst_out_d   = '1;
      if (state_q != ST_HOLD) begin
        // Leaving release/run: a fresh episode with its own cause set.
        cause_d = src;
        if (count_q != 8'hFF) begin
          count_d = count_q + 8'd1;
        end
      end else begin
        cause_d = cause_q | src;
      end
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d  = '0;
            gap_cnt_d   = '0;
            stage_idx_d = IDX_W'(1);
            // Shifting in a zero from the bottom keeps the output thermometer-shaped.
            rst_out_d   = rst_out_q << 1;
            state_d     = (NUM_STAGES == 1) ? ST_RUN : ST_RELEASE;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_RELEASE: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d   = '0;
            rst_out_d   = rst_out_q << 1;
            stage_idx_d = stage_idx_q + IDX_W'(1);
            if (stage_idx_q == IDX_LAST) begin
              state_d = ST_RUN;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
        ST_RUN: begin
          rst_out_d = '0;
        end
        default: begin
          state_d   = ST_HOLD;
          rst_out_d = '1;
        end
      endcase
    end

    busy_d = |rst_out_d;
  end

  // State and output registers; reset holds every domain in reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_HOLD;
      hold_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      stage_idx_q    <= '0;
      rst_out_q      <= '1;
      busy_q         <= 1'b1;
      mode_latched_q <= '0;
      cause_q        <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      stage_idx_q    <= stage_idx_d;
      rst_out_q      <= rst_out_d;
      busy_q         <= busy_d;
      mode_latched_q <= mode_latched_d;
      cause_q        <= cause_d;
      count_q        <= count_d;
    end
  end

  assign bus.rst_out      = rst_out_q;
  assign bus.busy         = busy_q;
  assign bus.mode_latched = mode_latched_q;
  assign bus.reset_cause  = cause_q;
  assign bus.reset_count  = count_q;

endmodule
